// File: rtl/matrix_ram_pkg.sv
// matrix_ram_master shared definitions: command encodings, FSM states and
// the byte-index width derivation.
package matrix_ram_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_DUMP  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        RD_REQ,
        RD_WAIT,
        RD_HOLD
    } state_e;

    // Linear byte index = word address plus 3 bits of byte lane.
    function automatic int idx_width(input int address_bits);
        return address_bits + 3;
    endfunction

endpackage

// File: rtl/matrix_ram_master_if.sv
// matrix_ram_master bus: command port, load/dump streams, RAM port and status.
// The master modport is the block's view; the slave modport is its
// environment (command source, stream endpoints and RAM).
interface matrix_ram_master_if
    import matrix_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_BITS = 2
);
    localparam int IDX_W = idx_width(ADDRESS_BITS);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [IDX_W-1:0]        cmd_start;
    logic [IDX_W-1:0]        cmd_count;
    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [DATA_WIDTH-1:0]   m_data;
    logic                    m_last;
    logic                    ram_enable_n;
    logic                    ram_wren_n;
    logic [ADDRESS_BITS-1:0] ram_address;
    logic [2:0]              ram_byteena;
    logic [DATA_WIDTH-1:0]   ram_data;
    logic [DATA_WIDTH-1:0]   ram_out;
    logic                    busy;
    logic                    cmd_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_start, cmd_count, s_valid, s_data, m_ready, ram_out,
        output cmd_ready, s_ready, m_valid, m_data, m_last,
               ram_enable_n, ram_wren_n, ram_address, ram_byteena, ram_data, busy, cmd_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_start, cmd_count, s_valid, s_data, m_ready, ram_out,
        input  cmd_ready, s_ready, m_valid, m_data, m_last,
               ram_enable_n, ram_wren_n, ram_address, ram_byteena, ram_data, busy, cmd_err
    );

endinterface

// File: rtl/matrix_ram_addr_gen.sv
// Byte-index walker: holds the current linear index (wrapping modulo
// 2**IDX_W) and the remaining-byte counter; last_o marks the final byte.
// idx_nxt_o exposes next cycle's index so registered RAM strobes can
// target it one cycle early.
module matrix_ram_addr_gen #(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [IDX_W-1:0] start_i,
    input  logic [IDX_W-1:0] count_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [IDX_W-1:0] idx_nxt_o,
    output logic             last_o
);
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rem_q, rem_d;

    // Next index / remaining count; natural overflow gives the wrap.
    always_comb begin
        idx_d = idx_q;
        rem_d = rem_q;
        if (load_i) begin
            idx_d = start_i;
            rem_d = count_i;
        end else if (step_i) begin
            idx_d = idx_q + IDX_W'(1);
            rem_d = rem_q - IDX_W'(1);
        end
    end

    // Index and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            rem_q <= '0;
        end else begin
            idx_q <= idx_d;
            rem_q <= rem_d;
        end
    end

    assign idx_o     = idx_q;
    assign idx_nxt_o = idx_d;
    assign last_o    = (rem_q == '0);

endmodule

// File: rtl/matrix_ram_master.sv
// matrix_ram_master: streams bytes into (load) or out of (dump) a byte-lane
// RAM over a linear byte index. All RAM port signals are registered.
// Optional op 10 (clear range to zero) is compiled in by defining
// MATRIX_RAM_MASTER_CLEAR_EN; otherwise op 10 is rejected like op 11.
module matrix_ram_master
    import matrix_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_BITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    matrix_ram_master_if.master bus
);
    localparam int IDX_W = idx_width(ADDRESS_BITS);

    state_e                  state_q, state_d;
    logic                    accept, step, last, wr, rd, err_d, err_q;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic                    en_n_q, en_n_d, wren_n_q, wren_n_d;
    logic [IDX_W-1:0]        strb_idx_q, strb_idx_d;
    logic [DATA_WIDTH-1:0]   ram_data_q, ram_data_d;
    cmd_op_e                 op;

    assign op     = cmd_op_e'(bus.cmd_op);
    // A trailing registered write still counts as busy.
    assign bus.busy      = (state_q != IDLE) || !en_n_q;
    assign bus.cmd_ready = !rst && !bus.busy;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    matrix_ram_addr_gen #(.IDX_W(IDX_W)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .step_i    (step),
        .start_i   (bus.cmd_start),
        .count_i   (bus.cmd_count),
        .idx_o     (idx),
        .idx_nxt_o (idx_nxt),
        .last_o    (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state plus write/read strobe decisions for the next cycle.
    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        wdata   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD: state_d = LOAD;
                        OP_DUMP: begin
                            state_d = RD_REQ;
                            rd      = 1'b1;
                        end
`ifdef MATRIX_RAM_MASTER_CLEAR_EN
                        OP_CLEAR: state_d = CLEAR;
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            LOAD: begin
                if (bus.s_valid) begin
                    wr    = 1'b1;
                    wdata = bus.s_data;
                    if (last) state_d = IDLE;
                    else      step    = 1'b1;
                end
            end
`ifdef MATRIX_RAM_MASTER_CLEAR_EN
            CLEAR: begin
                wr = 1'b1;
                if (last) state_d = IDLE;
                else      step    = 1'b1;
            end
`endif
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: state_d = RD_HOLD;
            RD_HOLD: begin
                if (bus.m_ready) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        step    = 1'b1;
                        rd      = 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes target the current index; reads are issued on entry to RD_REQ,
    // when the index is only just being loaded/stepped, so use the next one.
    always_comb begin
        en_n_d     = !(wr || rd);
        wren_n_d   = !wr;
        strb_idx_d = strb_idx_q;
        ram_data_d = ram_data_q;
        if (wr) begin
            strb_idx_d = idx;
            ram_data_d = wdata;
        end else if (rd) begin
            strb_idx_d = idx_nxt;
        end
    end

    // Registered RAM port.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_n_q     <= 1'b1;
            wren_n_q   <= 1'b1;
            strb_idx_q <= '0;
            ram_data_q <= '0;
        end else begin
            en_n_q     <= en_n_d;
            wren_n_q   <= wren_n_d;
            strb_idx_q <= strb_idx_d;
            ram_data_q <= ram_data_d;
        end
    end

    // Capture RAM read data in RD_WAIT; held through RD_HOLD.
    always_ff @(posedge clk) begin
        if (rst)                    m_data_q <= '0;
        else if (state_q == RD_WAIT) m_data_q <= bus.ram_out;
    end

    // Single-cycle rejection pulse.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.ram_enable_n = en_n_q;
    assign bus.ram_wren_n   = wren_n_q;
    assign bus.ram_address  = strb_idx_q[IDX_W-1:3];
    assign bus.ram_byteena  = strb_idx_q[2:0];
    assign bus.ram_data     = ram_data_q;
    assign bus.s_ready      = (state_q == LOAD);
    assign bus.m_valid      = (state_q == RD_HOLD);
    assign bus.m_last       = (state_q == RD_HOLD) && last;
    assign bus.m_data       = m_data_q;
    assign bus.cmd_err      = err_q;

endmodule

// File: tb/tb_matrix_ram_master.sv
// Directed bench for matrix_ram_master with a behavioural byte-lane RAM.
// Works with or without MATRIX_RAM_MASTER_CLEAR_EN.
module tb_matrix_ram_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_ram_master_if #(.DATA_WIDTH(8), .ADDRESS_BITS(2)) bus();

    matrix_ram_master #(.DATA_WIDTH(8), .ADDRESS_BITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: one-cycle read latency, write log with cycle stamps.
    logic [7:0] mem [0:31];
    int         cyc = 0;
    int         rd_n = 0;
    int         wr_idx[$];
    int         wr_cyc[$];
    wire  [4:0] lin = {bus.ram_address, bus.ram_byteena};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!bus.ram_enable_n && !bus.ram_wren_n) begin
            mem[lin] <= bus.ram_data;
            wr_idx.push_back(int'(lin));
            wr_cyc.push_back(cyc);
        end
        if (!bus.ram_enable_n && bus.ram_wren_n) begin
            bus.ram_out <= mem[lin];
            rd_n        <= rd_n + 1;
        end
    end

    int n_run = 0;
    int n_fail = 0;
    logic [7:0] vec [0:31];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [4:0] st, input logic [4:0] cnt);
        int g = 0;
        while (!bus.cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_start = st;
        bus.cmd_count = cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic load(input logic [4:0] st, input logic [4:0] cnt);
        int   n = int'(cnt) + 1;
        int   i = 0;
        int   g = 0;
        logic hs;
        send_cmd(2'b00, st, cnt);
        while (i < n && g < 400) begin
            bus.s_valid = 1'b1;
            bus.s_data  = vec[i];
            hs = bus.s_ready;
            @(posedge clk);
            if (hs) i++;
            @(negedge clk);
            g++;
        end
        bus.s_valid = 1'b0;
        chk("load_cnt", i, n);
    endtask

    task automatic dump(input logic [4:0] st, input logic [4:0] cnt);
        int n = int'(cnt) + 1;
        int got = 0;
        int g = 0;
        send_cmd(2'b01, st, cnt);
        bus.m_ready = 1'b1;
        while (got < n && g < 400) begin
            if (bus.m_valid) begin
                chk($sformatf("dump_data[%0d]", got), bus.m_data, vec[got]);
                chk($sformatf("dump_last[%0d]", got), bus.m_last, (got == n - 1));
                got++;
            end
            @(negedge clk);
            g++;
        end
        bus.m_ready = 1'b0;
        chk("dump_cnt", got, n);
    endtask

    initial begin
        int w0, r0, bad, ew;
        int wexp[4] = '{30, 31, 0, 1};
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_start = '0;
        bus.cmd_count = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b0;

        // Reset values, then ready right after release.
        repeat (2) @(negedge clk);
        chk("rst_ram", {bus.ram_enable_n, bus.ram_wren_n, bus.ram_address, bus.ram_byteena, bus.ram_data},
            {1'b1, 1'b1, 13'd0});
        chk("rst_ctl", {bus.cmd_ready, bus.s_ready, bus.m_valid, bus.m_data, bus.m_last, bus.busy, bus.cmd_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", bus.cmd_ready, 1);

        // Reserved op: err pulse, no RAM access.
        w0 = wr_idx.size(); r0 = rd_n;
        send_cmd(2'b11, 5'd3, 5'd2);
        chk("op11_err", bus.cmd_err, 1);
        chk("op11_busy", bus.busy, 0);
        @(negedge clk);
        chk("op11_err_pulse", bus.cmd_err, 0);
        chk("op11_noram", (wr_idx.size() - w0) + (rd_n - r0), 0);

        // Wrapping load 30,31,0,1 and readback.
        vec[0] = 8'hA1; vec[1] = 8'hA2; vec[2] = 8'hA3; vec[3] = 8'hA4;
        w0 = wr_idx.size();
        load(5'd30, 5'd3);
        chk("wrap_busy_tail", bus.busy, 1);
        chk("wrap_rdy_tail", bus.cmd_ready, 0);
        @(negedge clk);
        chk("wrap_idle", bus.busy, 0);
        for (int k = 0; k < 4; k++) chk($sformatf("wrap_wr_idx[%0d]", k), wr_idx[w0 + k], wexp[k]);
        dump(5'd30, 5'd3);

        // Backpressured 2-byte dump: latency, hold stability, busy ignores commands.
        send_cmd(2'b01, 5'd30, 5'd1);
        chk("lat_t1_strobe", {bus.ram_enable_n, bus.ram_wren_n}, 2'b01);
        chk("lat_t1_mv", bus.m_valid, 0);
        @(negedge clk);
        chk("lat_t2_mv", bus.m_valid, 0);
        chk("lat_t2_strobe", bus.ram_enable_n, 1);
        @(negedge clk);
        chk("lat_t3_mv", bus.m_valid, 1);
        chk("lat_t3_data", bus.m_data, 8'hA1);
        chk("lat_t3_last", bus.m_last, 0);
        r0 = rd_n;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        repeat (5) begin
            @(negedge clk);
            chk("hold_mv", bus.m_valid, 1);
            chk("hold_data", bus.m_data, 8'hA1);
            chk("hold_no_accept", bus.cmd_ready, 0);
            chk("hold_no_err", bus.cmd_err, 0);
        end
        bus.cmd_valid = 1'b0;
        chk("hold_no_rd", rd_n - r0, 0);
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        chk("hold_rdreq", {bus.ram_enable_n, bus.ram_wren_n}, 2'b01);
        chk("hold_mv_drop", bus.m_valid, 0);
        repeat (2) @(negedge clk);
        chk("b2_mv", bus.m_valid, 1);
        chk("b2_data", bus.m_data, 8'hA2);
        chk("b2_last", bus.m_last, 1);
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        chk("b2_done_mv", bus.m_valid, 0);
        chk("b2_done_busy", bus.busy, 0);

        // Whole RAM: 32 back-to-back writes then full dump.
        for (int k = 0; k < 32; k++) vec[k] = 8'(k);
        w0 = wr_idx.size();
        load(5'd0, 5'd31);
        @(negedge clk);
        chk("full_wr_n", wr_idx.size() - w0, 32);
        chk("full_consec", wr_cyc[w0 + 31] - wr_cyc[w0], 31);
        bad = 0;
        for (int k = 0; k < 32; k++) if (wr_idx[w0 + k] != k) bad++;
        chk("full_wr_order", bad, 0);
        dump(5'd0, 5'd31);

        // Op 10 on bytes 4-5.
        w0 = wr_idx.size();
        send_cmd(2'b10, 5'd4, 5'd1);
`ifdef MATRIX_RAM_MASTER_CLEAR_EN
        chk("clr_err", bus.cmd_err, 0);
        chk("clr_sready", bus.s_ready, 0);
        vec[0] = 8'h00; vec[1] = 8'h00; ew = 2;
`else
        chk("clr_err", bus.cmd_err, 1);
        vec[0] = 8'h04; vec[1] = 8'h05; ew = 0;
`endif
        repeat (4) @(negedge clk);
        chk("clr_wr_n", wr_idx.size() - w0, ew);
        dump(5'd4, 5'd1);

        // Reset during the 3rd byte of a 4-byte load at index 8.
        w0 = wr_idx.size();
        send_cmd(2'b00, 5'd8, 5'd3);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        @(negedge clk);
        bus.s_data  = 8'h66;
        @(negedge clk);
        bus.s_data  = 8'h77;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_en", bus.ram_enable_n, 1);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_sready", bus.s_ready, 0);
        rst = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr_n", wr_idx.size() - w0, 2);
        vec[0] = 8'h55; vec[1] = 8'h66; vec[2] = 8'h0A;
        dump(5'd8, 5'd2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/matrix_ram_master.md
MATRIX_RAM_MASTER -- requirements
Module: matrix_ram_master

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, byte width of the data path; only 8 is supported.
REQ-002 Parameter: ADDRESS_BITS, default 2, RAM word-address width; the RAM holds 2**ADDRESS_BITS words of 8 bytes each.
REQ-003 Derived constant: IDX_W = ADDRESS_BITS+3, the linear byte-index width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, clock; all logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted when both cmd_valid and cmd_ready are high.
- cmd_op, in, 2, 00 load, 01 dump, 10 clear, 11 reserved.
- cmd_start, in, IDX_W, first linear byte index.
- cmd_count, in, IDX_W, byte count minus 1.
- s_valid, s_ready, s_data: in 1, out 1, in DATA_WIDTH; load input stream.
- m_valid, m_ready, m_data, m_last: out 1, in 1, out DATA_WIDTH, out 1; dump output stream.
- ram_enable_n, out, 1, RAM active-low chip enable.
- ram_wren_n, out, 1, RAM active-low write enable.
- ram_address, out, ADDRESS_BITS, RAM word address.
- ram_byteena, out, 3, byte lane within the word.
- ram_data, out, DATA_WIDTH, RAM write data.
- ram_out, in, DATA_WIDTH, RAM read data, valid one cycle after the read strobe.
- busy, out, 1, a command is in progress.
- cmd_err, out, 1, one-cycle pulse when a command is rejected.

Function
REQ-006 All ram_* outputs SHALL be registered, so a strobe decided in cycle T is visible on the RAM ports in cycle T+1.
REQ-007 The byte index idx SHALL map as ram_address = idx[IDX_W-1:3] and ram_byteena = idx[2:0].
REQ-008 idx SHALL increment by 1 per byte and wrap modulo 2**IDX_W (index 31 is followed by 0 at defaults).
REQ-009 FSM states SHALL be IDLE, LOAD, CLEAR, RD_REQ, RD_WAIT and RD_HOLD.
REQ-010 In IDLE, cmd_ready SHALL equal !busy.
REQ-011 On command acceptance, idx SHALL load cmd_start and the remaining-byte counter SHALL load cmd_count.
REQ-012 LOAD: s_ready is 1; on each s handshake the next cycle SHALL show ram_enable_n=0, ram_wren_n=0 and ram_data equal to that s_data; sustained throughput is one byte per cycle.
REQ-013 LOAD: the handshake that consumes the final byte SHALL return the FSM to IDLE.
REQ-014 Dump, step 1: the transition into RD_REQ SHALL assert ram_enable_n=0 and ram_wren_n=1 during RD_REQ only.
REQ-015 Dump, step 2: in RD_WAIT, ram_out SHALL be captured into m_data.
REQ-016 Dump, step 3: in RD_HOLD, m_valid SHALL be 1 and m_data SHALL be held stable until m_ready.
REQ-017 Dump latency SHALL be: command accepted in cycle T gives m_valid=1 in cycle T+3.
REQ-018 On an RD_HOLD handshake the FSM SHALL go to RD_REQ, or to IDLE if that byte was the last.
REQ-019 m_last SHALL be 1 exactly with the final dumped byte.
REQ-020 Outside the command in progress, s_ready SHALL be 0 and m_valid SHALL be 0.
REQ-021 Outside write and read strobes, ram_enable_n SHALL be 1 and ram_wren_n SHALL be 1.
REQ-022 busy SHALL equal (state != IDLE) OR (ram_enable_n == 0), so a trailing write keeps busy high for one extra cycle.
REQ-023 cmd_count = 2**IDX_W-1 SHALL cover the whole RAM, each byte exactly once.
REQ-024 cmd_valid while busy SHALL be ignored (not accepted).
REQ-025 Op 11 SHALL be accepted, cause no RAM access and pulse cmd_err for one cycle.

Reset
REQ-026 While rst is high the FSM SHALL go to IDLE and the counters SHALL clear.
REQ-027 Reset values SHALL be: ram_enable_n=1, ram_wren_n=1, ram_address=0, ram_byteena=0, ram_data=0.
REQ-028 Reset values SHALL be: cmd_ready=0, s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, cmd_err=0.
REQ-029 Reset mid-command SHALL abort the command with no further RAM strobe; bytes already written remain in the RAM.
REQ-030 cmd_ready SHALL rise in the first cycle after rst falls.

Configuration
REQ-031 The macro MATRIX_RAM_MASTER_CLEAR_EN SHALL compile op 10 in or out.
REQ-032 With MATRIX_RAM_MASTER_CLEAR_EN defined: op 10 SHALL enter CLEAR and write 0 to cmd_count+1 bytes, one per cycle, with no stream involvement.
REQ-033 Without MATRIX_RAM_MASTER_CLEAR_EN: op 10 SHALL behave as op 11, and no CLEAR state logic SHALL exist.

Structure
REQ-034 Package matrix_ram_pkg SHALL hold the cmd_op encodings, the FSM state enum and the IDX_W derivation.
REQ-035 Sub-module matrix_ram_addr_gen SHALL hold the idx register, the wrap-around, the remaining-byte counter and the last flag.

Verification
REQ-036 Load start=0, count=31, bytes 0x00..0x1F one per cycle -> 32 consecutive write strobes; then dump the same range -> m_data 0x00..0x1F, m_last on 0x1F.
REQ-037 Load start=30, count=3, data A1,A2,A3,A4 -> writes at (addr3,lane6), (3,7), (0,0), (0,1); dump the same range returns A1..A4.
REQ-038 Dump of 2 bytes with m_ready held low 5 cycles -> m_data stable, no second RD_REQ until the handshake; first m_valid at T+3.
REQ-039 rst asserted during the 3rd byte of a 4-byte load -> next cycle ram_enable_n=1, busy=0; bytes 1-2 persist, byte 3 is not written.
REQ-040 Op 11 -> cmd_err pulses one cycle, no RAM strobe; op 10 start=4, count=1 -> bytes 4-5 read 0x00 with CLEAR_EN, cmd_err pulse without it.
